// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcode values, instruction
// field positions, decoded-instruction struct and sequencer states.
package fetch_seq_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int REG_HI = 11;
    localparam int REG_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_MOVR = 4'b0010;
    localparam logic [3:0] OP_MOVI = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_RL   = 4'b0111;
    localparam logic [3:0] OP_ST   = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    typedef struct packed {
        logic       is_ex;
        logic       is_jz;
        logic       is_halt;
        logic       is_illegal;
        logic [3:0] op;
        logic [3:0] rg;
        logic [7:0] imm;
    } dec_t;

endpackage

// File: rtl/fetch_seq_instr_decode.sv
// Combinational instruction decoder: classifies the opcode and splits out the
// operand fields. Shared with the datapath.
module instr_decode
    import fetch_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output dec_t               dec
);

    always_comb begin
        dec            = '0;
        dec.op         = ir[OP_HI:OP_LO];
        dec.rg         = ir[REG_HI:REG_LO];
        dec.imm        = ir[IMM_HI:IMM_LO];
        case (ir[OP_HI:OP_LO])
            OP_MOVR, OP_MOVI, OP_ADD, OP_SUB, OP_RL, OP_ST: dec.is_ex = 1'b1;
            OP_JZ:   dec.is_jz      = 1'b1;
            OP_HALT: dec.is_halt    = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction sequencer: owns the PC, fetches from a synchronous-read ROM and
// offers datapath instructions on a valid/ready handshake.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int N = ADDR_W,
    parameter int M = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         rom_rd,
    output logic [N-1:0] rom_addr,
    input  logic [M-1:0] rom_data,
    output logic         ex_valid,
    output logic [3:0]   ex_op,
    output logic [3:0]   ex_reg,
    output logic [7:0]   ex_imm,
    input  logic         ex_ready,
    output logic [3:0]   zsel,
    input  logic         reg_zero,
    output logic [N-1:0] pc,
    output logic         halted,
    output logic         illegal_op,
    output state_t       dbg_state
);

    // Handshake: an instruction transfers on a rising edge where ex_valid and
    // ex_ready are both high; ex_valid and its fields hold until then, and
    // ex_valid never depends combinationally on ex_ready.

    localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state, state_n;
    logic [N-1:0]   pc_n;
    logic [M-1:0]   ir;
    logic [N-1:0]   addr_q;
    dec_t           dec;

    instr_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            addr_q <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (state == ST_LOAD)
                ir <= rom_data;
            if (state == ST_FETCH)
                addr_q <= pc;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_n = ST_FETCH;
            end
            ST_FETCH: state_n = ST_LOAD;
            ST_LOAD:  state_n = ST_EXEC;
            ST_EXEC: begin
                if (dec.is_ex) begin
                    if (ex_ready) begin
                        pc_n    = pc + PC_ONE;
                        state_n = ST_FETCH;
                    end
                end else if (dec.is_jz) begin
                    pc_n    = reg_zero ? ir[N-1:0] : pc + PC_ONE;
                    state_n = ST_FETCH;
                end else if (dec.is_halt) begin
                    state_n = ST_HALT;
                end else begin
                    pc_n    = pc + PC_ONE;
                    state_n = ST_FETCH;
                end
            end
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_IDLE;
        endcase
    end

    // Address tracks pc during the read cycle and otherwise holds the last one.
    assign rom_rd     = (state == ST_FETCH);
    assign rom_addr   = rom_rd ? pc : addr_q;
    assign ex_valid   = (state == ST_EXEC) && dec.is_ex;
    assign ex_op      = dec.op;
    assign ex_reg     = dec.rg;
    assign ex_imm     = dec.imm;
    assign zsel       = ir[REG_HI:REG_LO];
    assign halted     = (state == ST_HALT);
    assign illegal_op = (state == ST_EXEC) && dec.is_illegal;
    assign dbg_state  = state;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus randomized programs checked
// against an instruction-level model of the program's execution.
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rom_rd;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [3:0]  ex_reg;
    logic [7:0]  ex_imm;
    logic        ex_ready = 1'b0;
    logic [3:0]  zsel;
    logic        reg_zero;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal_op;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom [256];
    logic [7:0]  rd_addr_q = '0;
    logic [15:0] zero_mask = '0;

    logic [7:0]  exp_fetch_q[$];
    logic [15:0] exp_q[$];

    logic [3:0] ex_ops  [6] = '{OP_MOVR, OP_MOVI, OP_ADD, OP_SUB, OP_RL, OP_ST};
    logic [3:0] bad_ops [8] = '{4'h0, 4'h1, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    fetch_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_reg     (ex_reg),
        .ex_imm     (ex_imm),
        .ex_ready   (ex_ready),
        .zsel       (zsel),
        .reg_zero   (reg_zero),
        .pc         (pc),
        .halted     (halted),
        .illegal_op (illegal_op),
        .dbg_state  (dbg_state)
    );

    // ---- clock / ROM / register-zero environment
    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rd_addr_q <= rom_addr;
    assign rom_data = rom[rd_addr_q];
    assign reg_zero = zero_mask[zsel];

    // ---- checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        ex_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    // Leaves the bench on the negedge where the first fetch is visible.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_fetch(input string tag, input logic [7:0] a, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (rom_rd && rom_addr == a) ok = 1'b1;
            else step(1);
        end
        check(tag, ok, 1'b1);
    endtask

    // ---- instruction-level reference model
    task automatic build_model(input int k, output int n_ill, output bit m_halt,
                               output logic [7:0] m_hpc);
        int a = 0;
        logic [15:0] ins;
        n_ill = 0;
        m_halt = 1'b0;
        m_hpc = '0;
        exp_fetch_q.delete();
        exp_q.delete();
        for (int n = 0; n < k; n++) begin
            ins = rom[a];
            exp_fetch_q.push_back(8'(a));
            if (ins[15:12] == OP_HALT) begin
                m_halt = 1'b1;
                m_hpc = 8'(a);
                break;
            end else if (ins[15:12] == OP_JZ) begin
                a = zero_mask[ins[11:8]] ? int'(ins[7:0]) : (a + 1) % 256;
            end else if (ins[15:12] inside {OP_MOVR, OP_MOVI, OP_ADD, OP_SUB, OP_RL, OP_ST}) begin
                exp_q.push_back(ins);
                a = (a + 1) % 256;
            end else begin
                n_ill++;
                a = (a + 1) % 256;
            end
        end
    endtask

    task automatic random_program();
        int r;
        logic [3:0] op;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12)      op = ex_ops[$urandom_range(0, 5)];
            else if (r < 16) op = OP_JZ;
            else if (r < 19) op = bad_ops[$urandom_range(0, 7)];
            else             op = OP_HALT;
            rom[i] = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
        end
        zero_mask = 16'($urandom);
    endtask

    task automatic run_random(input int iter);
        int exp_ill, ill_cnt, gap, stalls;
        bit m_halt, done, seen, prev_stall;
        logic [7:0] m_hpc, a;
        logic [15:0] held, e;
        random_program();
        build_model(40, exp_ill, m_halt, m_hpc);
        ill_cnt = 0; gap = 0; stalls = 0;
        done = 1'b0; seen = 1'b0; prev_stall = 1'b0;
        held = '0;
        pulse_start();
        for (int c = 0; c < 1500 && !done; c++) begin
            if (rom_rd) begin
                if (exp_fetch_q.size() == 0) begin
                    done = 1'b1;
                end else begin
                    if (seen) check("rand_gap", gap, 3 + stalls);
                    a = exp_fetch_q.pop_front();
                    check("rand_fetch", rom_addr, a);
                    gap = 0; stalls = 0; seen = 1'b1;
                end
            end
            if (!done) begin
                if (illegal_op) ill_cnt++;
                if (prev_stall) check("rand_hold", {ex_valid, ex_op, ex_reg, ex_imm}, {1'b1, held});
                prev_stall = 1'b0;
                ex_ready = ($urandom_range(0, 3) != 0);
                if (ex_valid) begin
                    if (ex_ready) begin
                        check("rand_ex_avail", exp_q.size() > 0, 1'b1);
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                        check("rand_ex", {ex_op, ex_reg, ex_imm}, e);
                    end else begin
                        stalls++;
                        prev_stall = 1'b1;
                        held = {ex_op, ex_reg, ex_imm};
                    end
                end
                if (halted) done = 1'b1;
                gap++;
                step(1);
            end
        end
        check("rand_timeout", done, 1'b1);
        check("rand_fetch_left", exp_fetch_q.size(), 0);
        check("rand_ex_left", exp_q.size(), 0);
        check("rand_illegal", ill_cnt, exp_ill);
        check("rand_halted", halted, m_halt);
        if (m_halt) check("rand_halt_pc", pc, m_hpc);
        if (iter < 0) $display("iteration %0d", iter);
    endtask

    // ---- main sequence
    initial begin
        int cnt;

        // reset state
        apply_reset();
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_fields", {ex_op, ex_reg, ex_imm}, 0);
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_state", dbg_state, ST_IDLE);
        step(3);
        check("idle_no_rd", rom_rd, 0);

        // two MOV #imm back to back
        fill_rom(16'hF000);
        rom[0] = 16'h3000;
        rom[1] = 16'h310A;
        ex_ready = 1'b1;
        pulse_start();
        check("t1_rd", rom_rd, 1);
        check("t1_addr", rom_addr, 0);
        step(1);
        check("t1_load_rd", rom_rd, 0);
        check("t1_load_valid", ex_valid, 0);
        step(1);
        check("t1_valid", ex_valid, 1);
        check("t1_fields", {ex_op, ex_reg, ex_imm}, 16'h3000);
        step(1);
        check("t1_rd2", rom_rd, 1);
        check("t1_addr2", rom_addr, 1);
        check("t1_pc", pc, 1);
        step(2);
        check("t1_valid2", ex_valid, 1);
        check("t1_fields2", {ex_op, ex_reg, ex_imm}, 16'h310A);

        // stalled handshake
        apply_reset();
        fill_rom(16'hF000);
        rom[0] = 16'h4010;
        pulse_start();
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", ex_valid, 1);
            check("t2_fields", {ex_op, ex_reg, ex_imm}, 16'h4010);
            check("t2_pc", pc, 0);
            step(1);
        end
        ex_ready = 1'b1;
        step(1);
        check("t2_pc_adv", pc, 1);
        check("t2_rd", rom_rd, 1);
        check("t2_addr", rom_addr, 1);

        // JZ taken and not taken
        for (int zr = 1; zr >= 0; zr--) begin
            apply_reset();
            fill_rom(16'hF000);
            for (int i = 0; i < 4; i++) rom[i] = 16'h3000;
            rom[4] = 16'h6108;
            zero_mask = (zr == 1) ? 16'h0002 : 16'hFFFD;
            ex_ready = 1'b1;
            pulse_start();
            wait_fetch("t3_reach4", 8'd4, 20);
            step(1);
            check("t3_load_valid", ex_valid, 0);
            step(1);
            check("t3_zsel", zsel, 1);
            check("t3_exec_valid", ex_valid, 0);
            step(1);
            check("t3_rd", rom_rd, 1);
            check("t3_target", rom_addr, (zr == 1) ? 8 : 5);
        end

        // HALT at pc 11
        apply_reset();
        fill_rom(16'hF000);
        for (int i = 0; i < 11; i++) rom[i] = 16'h3000;
        rom[11] = 16'hF00B;
        ex_ready = 1'b1;
        pulse_start();
        wait_fetch("t4_reach11", 8'd11, 60);
        step(2);
        check("t4_exec_halted", halted, 0);
        step(1);
        check("t4_halted", halted, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            step(1);
            if (rom_rd) cnt++;
        end
        start = 1'b0;
        check("t4_no_reads", cnt, 0);
        check("t4_still_halted", halted, 1);
        check("t4_pc", pc, 11);

        // illegal opcode, then JZ to 0xFF and wrap
        apply_reset();
        check("t5_halt_cleared", halted, 0);
        fill_rom(16'hF000);
        rom[0] = 16'h9000;
        rom[1] = 16'h60FF;
        rom[255] = 16'h3000;
        zero_mask = 16'h0001;
        ex_ready = 1'b1;
        pulse_start();
        step(1);
        check("t5_load_ill", illegal_op, 0);
        step(1);
        check("t5_ill", illegal_op, 1);
        check("t5_ill_valid", ex_valid, 0);
        step(1);
        check("t5_ill_off", illegal_op, 0);
        check("t5_rd", rom_rd, 1);
        check("t5_addr1", rom_addr, 1);
        wait_fetch("t5_reach255", 8'd255, 10);
        step(2);
        check("t5_valid255", ex_valid, 1);
        step(1);
        check("t5_wrap_addr", rom_addr, 0);
        check("t5_wrap_pc", pc, 0);
        check("t5_wrap_rd", rom_rd, 1);

        // async reset mid-handshake
        apply_reset();
        fill_rom(16'hF000);
        rom[0] = 16'h6000;
        rom[1] = 16'h3000;
        zero_mask = 16'h0000;
        pulse_start();
        wait_fetch("t6_reach1", 8'd1, 10);
        step(2);
        check("t6_valid", ex_valid, 1);
        check("t6_pc", pc, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", ex_valid, 0);
        check("t6_async_rd", rom_rd, 0);
        check("t6_async_pc", pc, 0);
        check("t6_async_halted", halted, 0);
        step(1);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (rom_rd || ex_valid) cnt++;
        end
        check("t6_stay_idle", cnt, 0);
        pulse_start();
        check("t6_restart_rd", rom_rd, 1);
        check("t6_restart_addr", rom_addr, 0);

        // randomized programs
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            run_random(it);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-sequencing controller for the simple processor. Owns the program counter and drives the synchronous-read program ROM (16-bit instructions: [15:12] opcode, [11:8] register, [7:0] immediate/address). Latches each instruction, resolves JZ and halt internally, and hands every other instruction to the datapath over a valid/ready handshake.

Parameters:
N, 8, program address width; PC and ROM address are N bits, wrapping modulo 2**N.
M, 16, instruction width; field positions are fixed as above.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin execution from PC=0; sampled only in IDLE.
rom_rd  out  1  ROM read enable.
rom_addr  out  N  ROM address.
rom_data  in  M  ROM read data, valid the cycle after rom_rd is sampled high.
ex_valid  out  1  instruction offered to datapath.
ex_op  out  4  opcode field.
ex_reg  out  4  register field.
ex_imm  out  8  immediate field.
ex_ready  in  1  datapath accepts the offered instruction this cycle.
zsel  out  4  register index whose zero status is requested (ir[11:8]).
reg_zero  in  1  combinational from datapath: register zsel equals 0.
pc  out  N  current program counter.
halted  out  1  halt executed.
illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, ir=0. rom_rd=0, rom_addr=0, ex_valid=0, halted=0, illegal_op=0, fields=0.
- All outputs are registered, or decoded from state/ir/pc registers only. No input-to-output combinational path.
- States: IDLE, FETCH, LOAD, EXEC, HALT.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: rom_rd=1 and rom_addr=pc for exactly this one cycle -> LOAD.
- LOAD: ir <= rom_data -> EXEC. rom_rd=0. rom_addr holds its last value.
- EXEC, decode of ir[15:12]:
  - 0010 MOV Rn,Rm; 0011 MOV Rn,#imm; 0100 ADD; 0101 SUB; 0111 RL; 1000 MOV mem,Rn:
    - ex_valid=1 with ex_op/ex_reg/ex_imm taken from ir.
    - On ex_valid&ex_ready: pc <= pc+1 -> FETCH.
    - Otherwise hold. Fields stay stable and ex_valid stays high until accepted.
  - 0110 JZ: no ex_valid. reg_zero is sampled this cycle; if 1, pc <= ir[N-1:0], else pc <= pc+1. -> FETCH.
  - 1111 HALT: pc unchanged -> HALT.
  - Any other opcode: illegal_op=1 for this cycle, no ex_valid, pc <= pc+1 -> FETCH.
- zsel = ir[11:8] at all times. The datapath may ignore it outside JZ.
- HALT: halted=1, no further ROM reads, start ignored. Leave only via rst.
- start outside IDLE is ignored.
- PC arithmetic is modulo 2**N: pc=2**N-1 then +1 gives 0.
- Throughput: 3 cycles per instruction when ex_ready=1 in the first EXEC cycle. JZ and illegal opcodes also take 3 cycles.
- rst asserted in any state, including mid-handshake with ex_valid=1, aborts the instruction. The datapath must not count it as accepted unless ex_ready was sampled high on a prior edge.

Decomposition:
- Shared package: opcode constants (OP_MOVR=4'b0010, OP_MOVI=4'b0011, OP_ADD=4'b0100, OP_SUB=4'b0101, OP_JZ=4'b0110, OP_RL=4'b0111, OP_ST=4'b1000, OP_HALT=4'b1111), field bit positions, and the state enumeration.
- One natural sub-module: instr_decode. It is combinational and maps ir to {is_ex, is_jz, is_halt, is_illegal, op, reg, imm}. It is reused later by the datapath.

Test Plan:
- Reset, start=1 for one cycle, ROM[0]=0x3000, ROM[1]=0x310A, ex_ready=1 -> rom_rd high with rom_addr=0. Two cycles later ex_valid=1, ex_op=3, ex_reg=0, ex_imm=0x00. Next FETCH at rom_addr=1, then ex_imm=0x0A.
- ROM[0]=0x4010, ex_ready held 0 for 5 EXEC cycles -> ex_valid stays 1, fields and pc=0 stay stable. Raise ex_ready -> pc=1 and next rom_addr=1.
- pc=4, ROM[4]=0x6108 -> zsel=1. reg_zero=1 gives next rom_addr=8; rerun with reg_zero=0 gives next rom_addr=5. ex_valid stays 0 throughout.
- ROM[11]=0xF00B at pc=11 -> halted=1 from the cycle after EXEC. No rom_rd for 20 cycles, start pulses ignored, pc=11.
- ROM[0]=0x9000 -> illegal_op single-cycle pulse, no ex_valid, next fetch rom_addr=1. JZ to 0xFF with reg_zero=1 and ROM[255]=0x3000 -> next fetch after 0xFF is rom_addr=0.
- Assert rst asynchronously mid-EXEC with ex_valid=1 -> ex_valid, rom_rd, pc and halted go to 0 before the next clock edge. After release the block stays in IDLE until start.
